// File: rtl/edib_cmd_tx.sv
// EDIB command/data line serial transmitter.
// Takes one 16-bit word plus a type flag and sends one frame on CMDOut:
// a 6-bit sync pattern, 16 data bits each followed by its complement, and then P and ~P.
// An optional idle-low gap follows each frame.
//
// Handshake (valid/ready): a word transfers on the rising Clk edge where TxValid=1 and
// TxReady=1. TxReady is high only in IDLE. The producer holds TxType/TxData stable while
// TxValid=1. The word is copied into a shadow shift register when it is accepted, so the
// inputs are don't-care after that edge.
module edib_cmd_tx #(
  parameter int BIT_CLKS = 576,
  parameter int GAP_BITS = 2
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        TxValid,
  input  logic        TxType,
  input  logic [15:0] TxData,
  output logic        TxReady,
  output logic        CMDOut,
  output logic        TxBusy,
  output logic        TxDone,
  output logic [15:0] FrameCount,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  localparam logic [11:0] CLK_LAST  = 12'(BIT_CLKS - 1);
  localparam logic [5:0]  SYNC_LAST = 6'd5;
  localparam logic [5:0]  PAY_LAST  = 6'd33;
  localparam logic [5:0]  GAP_LAST  = (GAP_BITS == 0) ? 6'd0 : 6'(GAP_BITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_clk_cnt;
  logic [5:0]  r_bit_cnt;
  logic [38:0] r_shift;
  logic        r_cmd_out;
  logic        r_done;
  logic [15:0] r_frame_count;
  logic [39:0] w_frame;
  logic        w_cmd_nxt;
  logic        w_accept;
  logic        w_bit_end;
  logic        w_frame_end;

  assign w_accept    = (r_state == S_IDLE) && TxValid;
  assign w_bit_end   = (r_clk_cnt == CLK_LAST);
  assign w_frame_end = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  assign TxReady    = (r_state == S_IDLE);
  assign TxBusy     = ~TxReady;
  assign CMDOut     = r_cmd_out;
  assign TxDone     = r_done;
  assign FrameCount = r_frame_count;
  assign DbgState   = r_state;

  // Assemble the whole 40-bit frame (sync, interleaved data/complement, parity pair) from the inputs.
  always_comb begin
    w_frame        = '0;
    w_frame[39:34] = TxType ? 6'b000111 : 6'b111000;
    for (int k = 0; k < 16; k++) begin
      w_frame[33 - 2*k] = TxData[15 - k];
      w_frame[32 - 2*k] = ~TxData[15 - k];
    end
    // P makes d15..d0,P hold an odd number of ones.
    w_frame[1] = ~^TxData;
    w_frame[0] = ^TxData;
  end

  // Next-state logic and the next line level, evaluated at bit boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd_out;
    case (r_state)
      S_IDLE: begin
        w_cmd_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt = S_SYNC;
          w_cmd_nxt   = w_frame[39];
        end
      end
      S_SYNC: begin
        if (w_bit_end && (r_bit_cnt == SYNC_LAST)) w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_bit_end && (r_bit_cnt == PAY_LAST)) begin
          w_state_nxt = (GAP_BITS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (w_bit_end && (r_bit_cnt == GAP_LAST)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Past the first bit, the line level changes only at a bit boundary. The line is driven
    // from the shadow register while frame bits remain, and is low during the gap and in IDLE.
    if ((r_state != S_IDLE) && w_bit_end) begin
      w_cmd_nxt = ((w_state_nxt == S_SYNC) || (w_state_nxt == S_PAYLOAD)) ? r_shift[38] : 1'b0;
    end
  end

  // State, bit-timing counters, shadow frame and registered line output.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_cmd_out     <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_out <= w_cmd_nxt;
      r_done    <= w_frame_end;
      if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;

      if ((r_state == S_IDLE) || w_bit_end) r_clk_cnt <= '0;
      else                                  r_clk_cnt <= r_clk_cnt + 12'd1;

      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end) begin
        r_bit_cnt <= (w_state_nxt != r_state) ? 6'd0 : r_bit_cnt + 6'd1;
      end

      if (w_accept)                         r_shift <= w_frame[38:0];
      else if ((r_state != S_IDLE) && w_bit_end) r_shift <= {r_shift[37:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_edib_cmd_tx.sv
// Testbench for edib_cmd_tx: randomized and directed words, a frame-level reference model,
// a queue-based scoreboard with an independent line monitor, mid-frame reset abort,
// and a zero-gap instance used for the FrameCount wrap.
`timescale 1ns/1ps
module tb_edib_cmd_tx;

  localparam int BC = 8;
  localparam int GB = 2;
  localparam int FB = 40 + GB;
  localparam int W  = 41;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rstn;
  logic        TxValid, TxType;
  logic [15:0] TxData;
  logic        TxReady, CMDOut, TxBusy, TxDone;
  logic [15:0] FrameCount;
  logic [1:0]  dbg;

  logic        TxValid_z, TxType_z;
  logic [15:0] TxData_z;
  logic        TxReady_z, CMDOut_z, TxBusy_z, TxDone_z;
  logic [15:0] FrameCount_z;
  logic [1:0]  dbg_z;

  edib_cmd_tx #(.BIT_CLKS(BC), .GAP_BITS(GB)) dut (
    .Clk(Clk), .Rstn(Rstn), .TxValid(TxValid), .TxType(TxType), .TxData(TxData),
    .TxReady(TxReady), .CMDOut(CMDOut), .TxBusy(TxBusy), .TxDone(TxDone),
    .FrameCount(FrameCount), .DbgState(dbg)
  );

  edib_cmd_tx #(.BIT_CLKS(BC), .GAP_BITS(0)) dut2 (
    .Clk(Clk), .Rstn(Rstn), .TxValid(TxValid_z), .TxType(TxType_z), .TxData(TxData_z),
    .TxReady(TxReady_z), .CMDOut(CMDOut_z), .TxBusy(TxBusy_z), .TxDone(TxDone_z),
    .FrameCount(FrameCount_z), .DbgState(dbg_z)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_fc;
  bit           mon_busy = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame as an ordered list of line bits, first bit at index 39.
  function automatic logic [39:0] model_frame(input logic t, input logic [15:0] d);
    bit          q[$];
    int          ones;
    logic [39:0] f;
    if (t) q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    else   q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ones = 0;
    for (int i = 15; i >= 0; i--) begin
      q.push_back(d[i]);
      q.push_back(!d[i]);
      if (d[i]) ones++;
    end
    q.push_back(bit'(ones % 2 == 0));
    q.push_back(bit'(ones % 2 != 0));
    f = '0;
    for (int i = 0; i < 40; i++) f[39 - i] = q[i];
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic t, input logic [15:0] d, input bit hold, input bit b2b);
    int n;
    n = 0;
    TxValid = 1'b1;
    TxType  = t;
    TxData  = d;
    while (TxReady !== 1'b1 && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL accept timeout: TxReady=%b, want 1", TxReady);
      TxValid = 1'b0;
      return;
    end
    exp_q.push_back({b2b, model_frame(t, d)});
    @(posedge Clk);
    #1;
    if (!hold) begin
      TxValid = 1'b0;
      TxType  = 1'($urandom);
      TxData  = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || TxReady !== 1'b1) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL idle timeout: queue=%0d busy=%0d, want 0/0", exp_q.size(), mon_busy);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic         busy_prev;
    logic [W-1:0] e;
    logic [7:0]   samp;
    bit           aborted;
    bit           ctl_ok;
    int           done_cyc;
    busy_prev = 1'b0;
    done_cyc  = -100;
    forever begin
      @(negedge Clk);
      if (Rstn && TxBusy === 1'b1 && !busy_prev) begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        ctl_ok   = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected frame: queue empty at frame start, want a queued word");
        end else begin
          e = exp_q.pop_front();
          if (e[40]) check("back-to-back start spacing", cyc - done_cyc, 1);
          for (int b = 0; b < FB && !aborted; b++) begin
            samp = '0;
            for (int c = 0; c < BC; c++) begin
              if (b > 0 || c > 0) @(negedge Clk);
              if (!Rstn) begin
                aborted = 1'b1;
                break;
              end
              samp[c] = CMDOut;
              if (TxDone !== 1'b0 || TxReady !== 1'b0 || TxBusy !== 1'b1) ctl_ok = 1'b0;
            end
            if (!aborted)
              check($sformatf("line bit %0d", b), samp, {8{(b < 40) ? e[39 - b] : 1'b0}});
          end
          if (!aborted) begin
            check("busy/ready/done during frame", ctl_ok, 1);
            @(negedge Clk);
            exp_fc = exp_fc + 16'd1;
            check("TxDone pulse", TxDone, 1);
            check("TxReady back", TxReady, 1);
            check("FrameCount", FrameCount, exp_fc);
            check("line low at idle", CMDOut, 0);
            done_cyc = cyc;
          end
        end
        mon_busy = 1'b0;
      end
      busy_prev = Rstn ? TxBusy : 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [39:0] f;
    logic [7:0]  samp;
    logic        t;
    logic [15:0] d;
    Rstn = 1'b0; TxValid = 1'b0; TxType = 1'b0; TxData = '0;
    TxValid_z = 1'b0; TxType_z = 1'b0; TxData_z = '0;
    exp_fc = '0;
    repeat (3) @(negedge Clk);
    Rstn = 1'b1;

    // Idle after reset with no request.
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      check("idle after reset", {CMDOut, TxReady, TxBusy, TxDone, FrameCount}, {4'b0100, 16'h0});
    end

    // Directed command and data words.
    send_word(1'b0, 16'hA5C3, 1'b0, 1'b0);
    wait_idle();
    send_word(1'b1, 16'h0001, 1'b0, 1'b0);
    wait_idle();

    // Random words with random idle spacing.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge Clk);
      send_word(1'($urandom), 16'($urandom), 1'b0, 1'b0);
      wait_idle();
    end

    // TxValid held with three queued words.
    @(negedge Clk);
    send_word(1'($urandom), 16'($urandom), 1'b1, 1'b0);
    send_word(1'($urandom), 16'($urandom), 1'b1, 1'b1);
    send_word(1'($urandom), 16'($urandom), 1'b0, 1'b1);
    wait_idle();

    // Reset in the middle of payload bit 20.
    @(negedge Clk);
    send_word(1'($urandom), 16'($urandom), 1'b0, 1'b0);
    repeat (26 * BC + 3) @(negedge Clk);
    #2;
    Rstn = 1'b0;
    #1;
    exp_fc = '0;
    check("abort line low", CMDOut, 0);
    check("abort ready", TxReady, 1);
    check("abort no done", TxDone, 0);
    check("abort FrameCount cleared", FrameCount, 0);
    repeat (3) @(negedge Clk);
    Rstn = 1'b1;
    @(negedge Clk);
    send_word(1'($urandom), 16'($urandom), 1'b0, 1'b0);
    wait_idle();

    // Zero-gap instance: FrameCount wrap from 0xFFFF.
    force dut2.r_frame_count = 16'hFFFF;
    @(negedge Clk);
    release dut2.r_frame_count;
    @(negedge Clk);
    check("preload FrameCount", FrameCount_z, 16'hFFFF);
    t = 1'($urandom);
    d = 16'($urandom);
    f = model_frame(t, d);
    TxValid_z = 1'b1; TxType_z = t; TxData_z = d;
    @(posedge Clk);
    #1;
    TxValid_z = 1'b0;
    TxData_z  = 16'($urandom);
    for (int b = 0; b < 40; b++) begin
      for (int c = 0; c < BC; c++) begin
        @(negedge Clk);
        samp[c] = CMDOut_z;
      end
      check($sformatf("nogap line bit %0d", b), samp, {8{f[39 - b]}});
    end
    @(negedge Clk);
    check("nogap TxDone", TxDone_z, 1);
    check("nogap TxReady", TxReady_z, 1);
    check("nogap FrameCount wrap", FrameCount_z, 16'h0000);
    check("nogap line low", CMDOut_z, 0);

    wait_idle();
    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    bad++;
    $display("FAIL global timeout: simulation still running, want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
